// File: rtl/code_logger_if.sv
// Event logger bus: detector code in, pop/clear controls,
// FIFO head, status flags and per-code counters out.
interface code_logger_if #(
  parameter int CW = 8
);
  logic [1:0]    y;
  logic          clr;
  logic          rd;
  logic [1:0]    code;
  logic          valid;
  logic          full;
  logic          ovf;
  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt2;
  logic [CW-1:0] cnt3;

  modport master (
    output y, clr, rd,
    input  code, valid, full, ovf,
    input  cnt1, cnt2, cnt3
  );

  modport slave (
    input  y, clr, rd,
    output code, valid, full, ovf,
    output cnt1, cnt2, cnt3
  );
endinterface

// File: rtl/code_logger.sv
// Logs non-zero detector codes: saturating per-code counts
// plus a FWFT FIFO of codes with a sticky overflow flag.
module code_logger #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input logic          clk,
  input logic          rst,
  code_logger_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          ovf;
  logic [CW-1:0] cnt [3];

  logic          evt;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic [2:0]    inc;

  // Occupancy flags from the extra-MSB pointer scheme
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) &&
            (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    evt   = (bus.y != 2'b00);
    pop   = bus.rd && !empty;
    push  = evt && (!full || pop);
  end

  // One-hot select of the counter matching the event code
  always_comb begin
    inc = 3'b000;
    unique case (1'b1)
      (bus.y == 2'b01): inc[0] = 1'b1;
      (bus.y == 2'b10): inc[1] = 1'b1;
      (bus.y == 2'b11): inc[2] = 1'b1;
      default: inc = 3'b000;
    endcase
  end

  // FIFO storage, pointers and sticky overflow; clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
    end else if (bus.clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= bus.y;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (evt && !push) ovf <= 1'b1;
    end
  end

  // Saturating per-code counters; dropped events still count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (inc[i] && cnt[i] != {CW{1'b1}})
          cnt[i] <= cnt[i] + 1'b1;
    end
  end

  // Outputs come only from registered state
  always_comb begin
    bus.code  = empty ? 2'b00 : mem[rd_ptr[AW-1:0]];
    bus.valid = !empty;
    bus.full  = full;
    bus.ovf   = ovf;
    bus.cnt1  = cnt[0];
    bus.cnt2  = cnt[1];
    bus.cnt3  = cnt[2];
  end

endmodule

// File: tb/tb_code_logger.sv
// Directed bench for code_logger: table of vectors plus
// hand sequences for reset, saturation and clear priority.
module tb_code_logger;

  logic clk;
  logic rst;

  code_logger_if #(.CW(8)) bus ();

  code_logger #(.DEPTH(4), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] y;
    logic       clr;
    logic       rd;
    logic [1:0] code;
    logic       valid;
    logic       full;
    logic       ovf;
    logic [7:0] c1;
    logic [7:0] c2;
    logic [7:0] c3;
  } vec_t;

  vec_t tv [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h, want %0h",
               name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int idx,
                         input logic [1:0] code,
                         input logic valid, input logic full,
                         input logic ovf, input logic [7:0] c1,
                         input logic [7:0] c2,
                         input logic [7:0] c3);
    chk({name, ".code"},  idx, 32'(bus.code),  32'(code));
    chk({name, ".valid"}, idx, 32'(bus.valid), 32'(valid));
    chk({name, ".full"},  idx, 32'(bus.full),  32'(full));
    chk({name, ".ovf"},   idx, 32'(bus.ovf),   32'(ovf));
    chk({name, ".cnt1"},  idx, 32'(bus.cnt1),  32'(c1));
    chk({name, ".cnt2"},  idx, 32'(bus.cnt2),  32'(c2));
    chk({name, ".cnt3"},  idx, 32'(bus.cnt3),  32'(c3));
  endtask

  task automatic step(input logic [1:0] y, input logic c,
                      input logic r);
    @(negedge clk);
    bus.y   = y;
    bus.clr = c;
    bus.rd  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] y, input logic c,
                     input logic r, input logic [1:0] code,
                     input logic v, input logic f,
                     input logic o, input logic [7:0] c1,
                     input logic [7:0] c2,
                     input logic [7:0] c3);
    vec_t t;
    t.y = y; t.clr = c; t.rd = r; t.code = code;
    t.valid = v; t.full = f; t.ovf = o;
    t.c1 = c1; t.c2 = c2; t.c3 = c3;
    tv.push_back(t);
  endtask

  initial begin
    rst     = 1'b1;
    bus.y   = 2'b00;
    bus.clr = 1'b0;
    bus.rd  = 1'b0;

    // ordered fill and drain; 4th rd on empty ignored
    add(1,0,0, 1,1,0,0, 1,0,0);
    add(2,0,0, 1,1,0,0, 1,1,0);
    add(3,0,0, 1,1,0,0, 1,1,1);
    add(0,0,1, 2,1,0,0, 1,1,1);
    add(0,0,1, 3,1,0,0, 1,1,1);
    add(0,0,1, 0,0,0,0, 1,1,1);
    add(0,0,1, 0,0,0,0, 1,1,1);
    // clear, then five 11 events into DEPTH 4
    add(0,1,0, 0,0,0,0, 0,0,0);
    add(3,0,0, 3,1,0,0, 0,0,1);
    add(3,0,0, 3,1,0,0, 0,0,2);
    add(3,0,0, 3,1,0,0, 0,0,3);
    add(3,0,0, 3,1,1,0, 0,0,4);
    add(3,0,0, 3,1,1,1, 0,0,5);
    add(0,0,1, 3,1,0,1, 0,0,5);
    add(0,0,1, 3,1,0,1, 0,0,5);
    add(0,0,1, 3,1,0,1, 0,0,5);
    add(0,0,1, 0,0,0,1, 0,0,5);
    // full with simultaneous pop and push
    add(0,1,0, 0,0,0,0, 0,0,0);
    add(3,0,0, 3,1,0,0, 0,0,1);
    add(3,0,0, 3,1,0,0, 0,0,2);
    add(3,0,0, 3,1,0,0, 0,0,3);
    add(3,0,0, 3,1,1,0, 0,0,4);
    add(2,0,1, 3,1,1,0, 0,1,4);
    add(0,0,1, 3,1,0,0, 0,1,4);
    add(0,0,1, 3,1,0,0, 0,1,4);
    add(0,0,1, 2,1,0,0, 0,1,4);
    add(0,0,1, 0,0,0,0, 0,1,4);
    // event with rd on empty FIFO is stored
    add(1,0,1, 1,1,0,0, 1,1,4);

    #2;
    chk_all("reset", 0, 0,0,0,0, 0,0,0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tv[i]) begin
      step(tv[i].y, tv[i].clr, tv[i].rd);
      chk_all("vec", i, tv[i].code, tv[i].valid, tv[i].full,
              tv[i].ovf, tv[i].c1, tv[i].c2, tv[i].c3);
    end

    // clear priority with 2 entries buffered
    step(0,1,0);
    step(1,0,0);
    step(2,0,0);
    chk_all("pre_clr", 0, 1,1,0,0, 1,1,0);
    step(2,1,0);
    chk_all("clr_prio", 0, 0,0,0,0, 0,0,0);

    // async reset mid-cycle with 3 entries and cnt1 = 5
    step(1,0,0);
    step(1,0,0);
    step(1,0,0);
    step(1,0,1);
    step(1,0,1);
    chk_all("pre_rst", 0, 1,1,0,0, 5,0,0);
    step(0,0,0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0,0,0,0, 0,0,0);
    @(negedge clk);
    rst = 1'b0;

    // saturation: 260 events of 01 with rd held high
    for (int i = 0; i < 260; i++) step(1,0,1);
    chk_all("sat", 0, 1,1,0,0, 255,0,0);
    step(0,0,1);
    chk_all("sat_drain", 0, 0,0,0,0, 255,0,0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
